// File: rtl/iot_event_encoder_if.sv
// Change/on_off event bus between the event encoder and the active-device counter.
// The encoder takes the master modport.
interface iot_event_encoder_if #(
   parameter int unsigned N_DEV = 8,
   parameter int unsigned ID_W  = 3,
   parameter int unsigned CNT_W = 8
);
   logic [N_DEV-1:0] dev_active;
   logic             hold;
   logic             change;
   logic             on_off;
   logic [ID_W-1:0]  dev_id;
   logic             busy;
   logic [CNT_W-1:0] active_count;

   modport master (
      input  dev_active,
      input  hold,
      output change,
      output on_off,
      output dev_id,
      output busy,
      output active_count
   );

   modport slave (
      output dev_active,
      output hold,
      input  change,
      input  on_off,
      input  dev_id,
      input  busy,
      input  active_count
   );
endinterface

// File: rtl/iot_event_encoder.sv
// Serialises net device on/off state changes into single-cycle change strobes,
// granting one device per cycle round-robin and tracking a shadow active count.
module iot_event_encoder #(
   parameter int unsigned N_DEV = 8,
   parameter int unsigned ID_W  = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   iot_event_encoder_if.master ev
);
   logic [N_DEV-1:0] level_q, level_d;
   logic [N_DEV-1:0] reported_q, reported_d;
   logic [N_DEV-1:0] pending;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  dev_id_q, dev_id_d;
   logic             change_q, change_d;
   logic             on_off_q, on_off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             gnt_valid;
   logic [ID_W-1:0]  gnt_idx;
   logic [ID_W:0]    scan_idx;

   // A device toggled back before being granted simply stops being pending.
   assign pending = level_q ^ reported_q;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < N_DEV; k++) begin
         // One extra bit so the wrap compare also works when N_DEV is not a power of two.
         scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(N_DEV)) begin
            scan_idx = scan_idx - (ID_W+1)'(N_DEV);
         end
         if (!gnt_valid && pending[scan_idx[ID_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      level_d    = ev.dev_active;
      reported_d = reported_q;
      rr_ptr_d   = rr_ptr_q;
      change_d   = 1'b0;
      on_off_d   = 1'b0;
      dev_id_d   = '0;
      cnt_d      = cnt_q;
      if (!ev.hold && gnt_valid) begin
         change_d            = 1'b1;
         on_off_d            = level_q[gnt_idx];
         dev_id_d            = gnt_idx;
         reported_d[gnt_idx] = level_q[gnt_idx];
         rr_ptr_d            = (gnt_idx == ID_W'(N_DEV - 1)) ? '0 : gnt_idx + ID_W'(1);
         cnt_d               = level_q[gnt_idx] ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q    <= '0;
         reported_q <= '0;
         rr_ptr_q   <= '0;
         change_q   <= 1'b0;
         on_off_q   <= 1'b0;
         dev_id_q   <= '0;
         cnt_q      <= '0;
      end else begin
         level_q    <= level_d;
         reported_q <= reported_d;
         rr_ptr_q   <= rr_ptr_d;
         change_q   <= change_d;
         on_off_q   <= on_off_d;
         dev_id_q   <= dev_id_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ev.change       = change_q;
   assign ev.on_off       = on_off_q;
   assign ev.dev_id       = dev_id_q;
   assign ev.active_count = cnt_q;
   assign ev.busy         = |pending;
endmodule

// File: tb/tb_iot_event_encoder.sv
// Bench for iot_event_encoder: event-level model checked every cycle plus directed
// pulse expectations; a CNT_W=2 instance shares the stimulus to exercise count wrap.
module tb_iot_event_encoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hold = 1'b0;
   logic [7:0] dev_active = 8'h00;

   int n_cmp = 0;
   int n_err = 0;

   iot_event_encoder_if #(.N_DEV(8), .ID_W(3), .CNT_W(8)) bus1 ();
   iot_event_encoder_if #(.N_DEV(8), .ID_W(3), .CNT_W(2)) bus2 ();

   assign bus1.dev_active = dev_active;
   assign bus1.hold       = hold;
   assign bus2.dev_active = dev_active;
   assign bus2.hold       = hold;

   iot_event_encoder #(.N_DEV(8), .ID_W(3), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .ev  (bus1)
   );

   iot_event_encoder #(.N_DEV(8), .ID_W(3), .CNT_W(2)) dut_w2 (
      .clk (clk),
      .rst (rst),
      .ev  (bus2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Event-level model: what has been sampled, what was last reported, where the scan starts.
   int m_lvl[8];
   int m_rep[8];
   int m_ptr;
   int m_chg, m_on, m_id, m_cnt;

   initial begin
      m_ptr = 0; m_chg = 0; m_on = 0; m_id = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         m_lvl[i] = 0;
         m_rep[i] = 0;
      end
      forever begin
         @(posedge clk);
         if (rst) begin
            m_ptr = 0; m_chg = 0; m_on = 0; m_id = 0; m_cnt = 0;
            for (int i = 0; i < 8; i++) begin
               m_lvl[i] = 0;
               m_rep[i] = 0;
            end
         end else begin
            int g;
            g = -1;
            m_chg = 0; m_on = 0; m_id = 0;
            if (!hold) begin
               for (int k = 0; k < 8; k++) begin
                  int i;
                  i = (m_ptr + k) % 8;
                  if (g < 0 && m_lvl[i] != m_rep[i]) g = i;
               end
            end
            if (g >= 0) begin
               m_chg    = 1;
               m_on     = m_lvl[g];
               m_id     = g;
               m_rep[g] = m_lvl[g];
               m_ptr    = (g + 1) % 8;
               m_cnt    = (m_lvl[g] != 0) ? m_cnt + 1 : m_cnt - 1;
            end
            for (int i = 0; i < 8; i++) m_lvl[i] = int'(dev_active[i]);
         end
      end
   end

   // Every-cycle comparison against the model, sampled on the falling edge.
   initial begin
      forever begin
         int busy_exp;
         logic [7:0] c8;
         logic [1:0] c2;
         @(negedge clk);
         busy_exp = 0;
         for (int i = 0; i < 8; i++) if (m_lvl[i] != m_rep[i]) busy_exp = 1;
         c8 = m_cnt[7:0];
         c2 = m_cnt[1:0];
         check("model change", int'(bus1.change), m_chg);
         check("model on_off", int'(bus1.on_off), m_on);
         check("model dev_id", int'(bus1.dev_id), m_id);
         check("model busy", int'(bus1.busy), busy_exp);
         check("model count", int'(bus1.active_count), int'(c8));
         check("model count w2", int'(bus2.active_count), int'(c2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input string nm, input int lat, input int on, input int id,
                        input int cnt);
      int c;
      c = 0;
      do begin
         tick();
         c++;
      end while (!bus1.change && c < 20);
      check({nm, " strobe"}, int'(bus1.change), 1);
      check({nm, " latency"}, c, lat);
      check({nm, " on_off"}, int'(bus1.on_off), on);
      check({nm, " dev_id"}, int'(bus1.dev_id), id);
      check({nm, " count"}, int'(bus1.active_count), cnt);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int exp_w2[4] = '{1, 2, 3, 0};

   initial begin
      // Reset state
      tick();
      tick();
      check("reset change", int'(bus1.change), 0);
      check("reset dev_id", int'(bus1.dev_id), 0);
      check("reset count", int'(bus1.active_count), 0);
      check("reset busy", int'(bus1.busy), 0);
      rst = 1'b0;

      // Single device on, then off
      dev_active = 8'h04;
      pulse("single on", 2, 1, 2, 1);
      tick();
      check("single no repeat", int'(bus1.change), 0);
      dev_active = 8'h00;
      pulse("single off", 2, 0, 2, 0);

      // Burst: all on from a fresh pointer, then all off after the pointer wraps
      do_reset();
      dev_active = 8'hFF;
      for (int i = 0; i < 8; i++) pulse("burst on", (i == 0) ? 2 : 1, 1, i, i + 1);
      check("burst busy low", int'(bus1.busy), 0);
      dev_active = 8'h00;
      for (int i = 0; i < 8; i++) pulse("burst off", (i == 0) ? 2 : 1, 0, i, 7 - i);

      // Cancellation under hold
      hold = 1'b1;
      dev_active = 8'h20;
      tick();
      tick();
      dev_active = 8'h00;
      tick();
      hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("cancel no pulse", int'(bus1.change), 0);
      end
      check("cancel busy", int'(bus1.busy), 0);
      check("cancel count", int'(bus1.active_count), 0);

      // Same, ending high: one pulse the cycle after hold drops
      hold = 1'b1;
      dev_active = 8'h20;
      tick();
      dev_active = 8'h00;
      tick();
      dev_active = 8'h20;
      tick();
      tick();
      check("hold suppress", int'(bus1.change), 0);
      hold = 1'b0;
      pulse("hold release", 1, 1, 5, 1);
      dev_active = 8'h00;
      pulse("dev5 off", 2, 0, 5, 0);

      // Count wrap on the 2-bit instance; scan restarts at 6 and wraps to 0
      dev_active = 8'h0F;
      for (int i = 0; i < 4; i++) begin
         pulse("wrap on", (i == 0) ? 2 : 1, 1, i, i + 1);
         check("wrap count w2", int'(bus2.active_count), exp_w2[i]);
      end
      dev_active = 8'h0E;
      pulse("wrap off", 2, 0, 0, 3);
      check("wrap off w2", int'(bus2.active_count), 3);

      // Reset mid-burst: pointer is at 1, so devices 4,5,6 go first
      dev_active = 8'hFF;
      for (int i = 0; i < 3; i++) pulse("pre-reset", (i == 0) ? 2 : 1, 1, 4 + i, 4 + i);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("mid reset change", int'(bus1.change), 0);
         check("mid reset dev_id", int'(bus1.dev_id), 0);
         check("mid reset count", int'(bus1.active_count), 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) pulse("post-reset", (i == 0) ? 2 : 1, 1, i, i + 1);
      tick();
      check("post-reset idle", int'(bus1.change), 0);
      check("post-reset busy", int'(bus1.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/iot_event_encoder.md
Name: iot_event_encoder

Overview:
- Transmit end of the change/on_off event interface consumed by the active-device counter.
- Watches N_DEV device activity levels and serialises every net state change into single-cycle change pulses, at most one per clock.
- on_off gives the direction of each pulse; dev_id identifies the device.
- Keeps a shadow active count equal to the value the downstream counter will hold after it captures each event.

Parameters:
N_DEV, 8, number of monitored devices (2..64)
ID_W, 3, dev_id width; must equal clog2(N_DEV)
CNT_W, 8, shadow counter width; must match the downstream counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
dev_active  input  N_DEV  level per device; 1 = device on; synchronous to clk
hold  input  1  1 = suppress new grants; pending events are retained
change  output  1  one-cycle event strobe to the counter
on_off  output  1  event direction; 1 = device turned on, 0 = turned off; valid when change=1, otherwise 0
dev_id  output  ID_W  index of the device reported; valid when change=1, otherwise 0
busy  output  1  1 when any device has an unreported state difference
active_count  output  CNT_W  shadow count of active devices

Behaviour:
- Registers:
  - level_r[N_DEV]: dev_active sampled every clock.
  - reported[N_DEV]: last state sent downstream per device.
  - rr_ptr[ID_W]: round-robin start index.
  - Output registers: change, on_off, dev_id, active_count.
- pending[i] = level_r[i] XOR reported[i], combinational.
  - A device toggling on then off before it is granted produces no event; the cancellation is natural.
- busy = OR of pending, combinational from registers.
- Grant:
  - When hold=0 and any pending bit is set, select the first pending index found scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_DEV.
  - Only one grant per cycle.
- On grant of index g, at the next edge:
  - change<=1, on_off<=level_r[g], dev_id<=g
  - reported[g]<=level_r[g]
  - rr_ptr<=(g+1) mod N_DEV
  - active_count<=active_count+1 if level_r[g]=1, else active_count-1, modulo 2^CNT_W; wrap is allowed and matches the downstream counter.
- No grant (hold=1 or nothing pending): change<=0, on_off<=0, dev_id<=0; active_count, reported and rr_ptr unchanged.
- Latency: a dev_active edge sampled at clock k is in level_r after k; with no contention and hold=0, change is high in the cycle after clock k+1. Minimum 2 cycles from input edge to strobe.
- Fairness: with all N_DEV devices pending continuously, every device is reported within N_DEV consecutive grant cycles.
- Same-cycle events:
  - A device granted in the same cycle its input flips again gets the old level reported.
  - Its new level becomes pending on the following cycle.
- hold: outputs drop to idle on the next edge; pending state accumulates as net differences; grants resume the cycle after hold falls.
- Reset behaviour:
  - Values: level_r=0, reported=0, rr_ptr=0, change=0, on_off=0, dev_id=0, active_count=0.
  - Devices already active when rst falls generate on events afterwards, starting with the lowest index.
  - Reset asserted mid-stream discards all pending events.
  - rst has priority over hold and grants.
- Width rules: dev_id zero-extended index; N_DEV not a power of two scans only indices 0..N_DEV-1.

Test Plan:
- Reset: rst=1 for 2 cycles with dev_active=8'h00 -> change=0, dev_id=0, active_count=0, busy=0.
- Single device: dev_active goes 8'h00->8'h04 -> exactly one change pulse 2 cycles later with on_off=1, dev_id=2, active_count=1. Then 8'h00 -> one pulse with on_off=0, dev_id=2, active_count=0.
- Burst and round-robin: 8'h00->8'hFF in one cycle -> 8 consecutive pulses with dev_id 0..7, all on_off=1, active_count 1..8, busy low after the last.
  - Then 8'h00 -> 8 off pulses starting at dev_id 0 (rr_ptr wrapped), ending at active_count=0.
- Cancellation and hold: hold=1, device 5 goes 0->1->0 over 3 cycles, then hold=0 -> no pulse, busy=0, active_count unchanged.
  - Same sequence with a final level of 1 -> exactly one on pulse, dev_id=5.
- Wrap-around: with CNT_W=2 override and 4 devices turned on -> active_count sequence 1,2,3,0.
  - Turning one device off -> 3.
- Reset mid-burst: 8'hFF applied, rst=1 after 3 pulses, dev_active held at 8'hFF -> outputs zero during reset.
  - After release: 8 on pulses dev_id 0..7, active_count ends at 8.
